// File: rtl/qcw_ramp_controller.sv
// -----------------------------------------------------------------------------
// qcw_ramp_controller
//
// Burst sequencer for the QCW H-bridge oscillator. A trigger edge starts a
// burst. The controller preloads the oscillator period and the start phase,
// then enables the oscillator for a programmed number of RF periods. On every
// period_done pulse it ramps the phase shift from start towards end, using a
// PHASE_W.FRAC_W fixed-point accumulator. After the burst it holds the
// oscillator off for max(cfg_holdoff, MIN_HOLDOFF) clock cycles.
//
// Optional feature: define QCW_SOFT_STOP_EN to enable a ramp-down phase. With
// it, a normal burst end walks the phase back to start before it disables the
// oscillator. Abort and watchdog always skip the ramp-down.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   cfg_*               burst configuration, captured on the accepted trigger
//   trigger             burst request (rising edge detected internally)
//   abort               level; stops an active burst immediately
//   period_done         1-cycle pulse from the oscillator at each period wrap
//   osc_enable          oscillator enable
//   osc_load            1-cycle strobe qualifying osc_period_value/phase_shift
//   osc_period_value    period handed to the oscillator
//   osc_phase_shift     phase handed to the oscillator
//   busy                high whenever the sequencer is not idle
//   burst_count         period_done pulses counted in current/last burst
//   trig_rejected       1-cycle pulse: trigger edge arrived while busy
//   fault               sticky period_done watchdog fault
// -----------------------------------------------------------------------------
module qcw_ramp_controller #(
  parameter int PERIOD_W    = 12,
  parameter int PHASE_W     = 8,
  parameter int FRAC_W      = 8,
  parameter int COUNT_W     = 16,
  parameter int HOLD_W      = 24,
  parameter int MIN_HOLDOFF = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic [PHASE_W-1:0]        cfg_phase_start,
  input  logic [PHASE_W-1:0]        cfg_phase_end,
  input  logic [PHASE_W+FRAC_W-1:0] cfg_ramp_step,
  input  logic [COUNT_W-1:0]        cfg_burst_len,
  input  logic [HOLD_W-1:0]         cfg_holdoff,
  input  logic                      trigger,
  input  logic                      abort,
  input  logic                      period_done,
  output logic                      osc_enable,
  output logic                      osc_load,
  output logic [PERIOD_W-1:0]       osc_period_value,
  output logic [PHASE_W-1:0]        osc_phase_shift,
  output logic                      busy,
  output logic [COUNT_W-1:0]        burst_count,
  output logic                      trig_rejected,
  output logic                      fault
);

  localparam int ACC_W = PHASE_W + FRAC_W;
  localparam int WD_W  = PERIOD_W + 2;  // holds 4 * period

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRELOAD  = 3'd1;
  localparam logic [2:0] S_RAMP     = 3'd2;
  localparam logic [2:0] S_RAMPDOWN = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;

  localparam logic [HOLD_W-1:0] L_MIN_HOLD = HOLD_W'(MIN_HOLDOFF);

  // State and shadow configuration
  logic [2:0]          r_state;
  logic                r_trig_d;
  logic [PHASE_W-1:0]  r_start;
  logic [PHASE_W-1:0]  r_end;
  logic [ACC_W-1:0]    r_step;
  logic [COUNT_W-1:0]  r_len;
  logic [HOLD_W-1:0]   r_holdoff;
  logic [ACC_W-1:0]    r_acc;
  logic [WD_W-1:0]     r_wd;
  logic [HOLD_W-1:0]   r_hold;

  // Output registers
  logic                r_osc_enable;
  logic                r_osc_load;
  logic [PERIOD_W-1:0] r_osc_period_value;
  logic [PHASE_W-1:0]  r_osc_phase_shift;
  logic                r_busy;
  logic [COUNT_W-1:0]  r_burst_count;
  logic                r_trig_rejected;
  logic                r_fault;

  // Next-state values
  logic [2:0]          w_state_nxt;
  logic [PHASE_W-1:0]  w_start_nxt;
  logic [PHASE_W-1:0]  w_end_nxt;
  logic [ACC_W-1:0]    w_step_nxt;
  logic [COUNT_W-1:0]  w_len_nxt;
  logic [HOLD_W-1:0]   w_holdoff_nxt;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [WD_W-1:0]     w_wd_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_en_nxt;
  logic                w_load_nxt;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic [PHASE_W-1:0]  w_phase_nxt;
  logic [COUNT_W-1:0]  w_cnt_nxt;
  logic                w_fault_nxt;

  // Datapath helpers
  logic                w_trig_edge;
  logic [ACC_W-1:0]    w_start_acc;
  logic [ACC_W-1:0]    w_end_acc;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W:0]      w_diff;
  logic [ACC_W-1:0]    w_up;
  logic [ACC_W-1:0]    w_down;
  logic [COUNT_W-1:0]  w_cnt_inc;
  logic                w_len_hit;
  logic [WD_W-1:0]     w_wd_limit;
  logic [WD_W-1:0]     w_wd_inc;
  logic                w_wd_expired;
  logic [HOLD_W-1:0]   w_hold_target;
  logic [HOLD_W:0]     w_hold_inc;
  logic                w_hold_done;

  assign w_trig_edge = trigger & ~r_trig_d;
  assign w_start_acc = {r_start, {FRAC_W{1'b0}}};
  assign w_end_acc   = {r_end, {FRAC_W{1'b0}}};

  // One guard bit on the sum catches overflow before the clamp against end.
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_step};
  assign w_up   = (w_sum > {1'b0, w_end_acc}) ? w_end_acc : w_sum[ACC_W-1:0];
  // A set guard bit on the difference means a borrow, so the result clamps to start.
  assign w_diff = {1'b0, r_acc} - {1'b0, r_step};
  assign w_down = (w_diff[ACC_W] || (w_diff < {1'b0, w_start_acc})) ?
                  w_start_acc : w_diff[ACC_W-1:0];

  assign w_cnt_inc = (&r_burst_count) ? r_burst_count : (r_burst_count + COUNT_W'(1));
  assign w_len_hit = (w_cnt_inc >= r_len);

  // osc_period_value holds the captured period for the whole burst.
  assign w_wd_limit   = {r_osc_period_value, 2'b00};
  assign w_wd_inc     = r_wd + WD_W'(1);
  assign w_wd_expired = (w_wd_inc >= w_wd_limit);

  assign w_hold_target = (r_holdoff > L_MIN_HOLD) ? r_holdoff : L_MIN_HOLD;
  assign w_hold_inc    = {1'b0, r_hold} + {{HOLD_W{1'b0}}, 1'b1};
  assign w_hold_done   = (w_hold_inc >= {1'b0, w_hold_target});

  // Sequencer next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_start_nxt   = r_start;
    w_end_nxt     = r_end;
    w_step_nxt    = r_step;
    w_len_nxt     = r_len;
    w_holdoff_nxt = r_holdoff;
    w_acc_nxt     = r_acc;
    w_wd_nxt      = r_wd;
    w_hold_nxt    = r_hold;
    w_en_nxt      = r_osc_enable;
    w_load_nxt    = 1'b0;
    w_period_nxt  = r_osc_period_value;
    w_phase_nxt   = r_osc_phase_shift;
    w_cnt_nxt     = r_burst_count;
    w_fault_nxt   = r_fault;

    case (r_state)
      S_IDLE: begin
        // abort held at the trigger edge suppresses the burst silently
        if (w_trig_edge && !abort) begin
          w_start_nxt   = cfg_phase_start;
          w_end_nxt     = cfg_phase_end;
          w_step_nxt    = cfg_ramp_step;
          w_len_nxt     = (cfg_burst_len == {COUNT_W{1'b0}}) ? COUNT_W'(1) : cfg_burst_len;
          w_holdoff_nxt = cfg_holdoff;
          w_acc_nxt     = {cfg_phase_start, {FRAC_W{1'b0}}};
          w_period_nxt  = cfg_period;
          w_phase_nxt   = cfg_phase_start;
          w_load_nxt    = 1'b1;
          w_cnt_nxt     = {COUNT_W{1'b0}};
          w_fault_nxt   = 1'b0;
          w_wd_nxt      = {WD_W{1'b0}};
          w_state_nxt   = S_PRELOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_PRELOAD: begin
        w_wd_nxt = {WD_W{1'b0}};
        if (abort) begin
          w_en_nxt    = 1'b0;
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_en_nxt    = 1'b1;
          w_state_nxt = S_RAMP;
        end
      end

      S_RAMP: begin
        if (abort) begin
          w_en_nxt    = 1'b0;
          w_wd_nxt    = {WD_W{1'b0}};
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_HOLDOFF;
        end else if (period_done) begin
          w_cnt_nxt = w_cnt_inc;
          w_wd_nxt  = {WD_W{1'b0}};
          // The terminating period_done ends the burst without a new load.
          if (w_len_hit) begin
`ifdef QCW_SOFT_STOP_EN
            w_state_nxt = S_RAMPDOWN;
`else
            w_en_nxt    = 1'b0;
            w_hold_nxt  = {HOLD_W{1'b0}};
            w_state_nxt = S_HOLDOFF;
`endif
          end else begin
            w_acc_nxt   = w_up;
            w_phase_nxt = w_up[ACC_W-1 -: PHASE_W];
            w_load_nxt  = 1'b1;
          end
        end else if (w_wd_expired) begin
          w_fault_nxt = 1'b1;
          w_en_nxt    = 1'b0;
          w_wd_nxt    = {WD_W{1'b0}};
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end

`ifdef QCW_SOFT_STOP_EN
      S_RAMPDOWN: begin
        if (abort) begin
          w_en_nxt    = 1'b0;
          w_wd_nxt    = {WD_W{1'b0}};
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_HOLDOFF;
        end else if (period_done) begin
          w_cnt_nxt = w_cnt_inc;
          w_wd_nxt  = {WD_W{1'b0}};
          if (r_acc == w_start_acc) begin
            w_en_nxt    = 1'b0;
            w_hold_nxt  = {HOLD_W{1'b0}};
            w_state_nxt = S_HOLDOFF;
          end else begin
            w_acc_nxt   = w_down;
            w_phase_nxt = w_down[ACC_W-1 -: PHASE_W];
            w_load_nxt  = 1'b1;
          end
        end else if (w_wd_expired) begin
          w_fault_nxt = 1'b1;
          w_en_nxt    = 1'b0;
          w_wd_nxt    = {WD_W{1'b0}};
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_HOLDOFF;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end
`endif

      S_HOLDOFF: begin
        // r_hold counts edges since osc_enable fell
        if (w_hold_done) begin
          w_hold_nxt  = {HOLD_W{1'b0}};
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = w_hold_inc[HOLD_W-1:0];
        end
      end

      default: begin
        w_en_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Register stage for state, shadow config and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_trig_d           <= 1'b0;
      r_start            <= {PHASE_W{1'b0}};
      r_end              <= {PHASE_W{1'b0}};
      r_step             <= {ACC_W{1'b0}};
      r_len              <= {COUNT_W{1'b0}};
      r_holdoff          <= {HOLD_W{1'b0}};
      r_acc              <= {ACC_W{1'b0}};
      r_wd               <= {WD_W{1'b0}};
      r_hold             <= {HOLD_W{1'b0}};
      r_osc_enable       <= 1'b0;
      r_osc_load         <= 1'b0;
      r_osc_period_value <= {PERIOD_W{1'b0}};
      r_osc_phase_shift  <= {PHASE_W{1'b0}};
      r_busy             <= 1'b0;
      r_burst_count      <= {COUNT_W{1'b0}};
      r_trig_rejected    <= 1'b0;
      r_fault            <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_trig_d           <= trigger;
      r_start            <= w_start_nxt;
      r_end              <= w_end_nxt;
      r_step             <= w_step_nxt;
      r_len              <= w_len_nxt;
      r_holdoff          <= w_holdoff_nxt;
      r_acc              <= w_acc_nxt;
      r_wd               <= w_wd_nxt;
      r_hold             <= w_hold_nxt;
      r_osc_enable       <= w_en_nxt;
      r_osc_load         <= w_load_nxt;
      r_osc_period_value <= w_period_nxt;
      r_osc_phase_shift  <= w_phase_nxt;
      r_busy             <= (w_state_nxt != S_IDLE);
      r_burst_count      <= w_cnt_nxt;
      r_trig_rejected    <= w_trig_edge && (r_state != S_IDLE);
      r_fault            <= w_fault_nxt;
    end
  end

  assign osc_enable       = r_osc_enable;
  assign osc_load         = r_osc_load;
  assign osc_period_value = r_osc_period_value;
  assign osc_phase_shift  = r_osc_phase_shift;
  assign busy             = r_busy;
  assign burst_count      = r_burst_count;
  assign trig_rejected    = r_trig_rejected;
  assign fault            = r_fault;

endmodule
